hs32_irq_cond: RTL and testbench

//   Interrupt source conditioning stage directly upstream of the AIC. Synchronises 24 raw

---
 rtl/hs32_irq_pkg.sv | 20 ++
 rtl/hs32_irq_sync.sv | 35 +++
 rtl/hs32_irq_cond.sv | 118 +++++++++++
 tb/tb_hs32_irq_cond.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/hs32_irq_pkg.sv
// Shared constants for the HS32 interrupt conditioning stage: line count,
// NMI lines and MMIO register word offsets.
package hs32_irq_pkg;

  localparam int NIRQ = 24;
  localparam logic [NIRQ-1:0] NMI_MASK = 24'h000003;

  localparam logic [4:0] REG_MODE = 5'd0;
  localparam logic [4:0] REG_POL  = 5'd1;
  localparam logic [4:0] REG_PEND = 5'd2;
  localparam logic [4:0] REG_MASK = 5'd3;
  localparam logic [4:0] REG_RAW  = 5'd4;
  localparam logic [4:0] REG_SWI  = 5'd5;

  // Zero-extend a line vector onto the 32-bit read bus.
  function automatic logic [31:0] zext_lines(input logic [NIRQ-1:0] v);
    return {8'h00, v};
  endfunction

endpackage

// File: rtl/hs32_irq_sync.sv
// Two-flop synchroniser per line with polarity normalisation and a
// previous-state register for rising-edge detection.
module hs32_irq_sync #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] async_in,
  input  logic [W-1:0] pol,
  output logic [W-1:0] norm,
  output logic [W-1:0] rise
);

  logic [W-1:0] sync1_r;
  logic [W-1:0] sync2_r;
  logic [W-1:0] prev_r;

  // Synchroniser chain and normalised-state history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= '0;
      sync2_r <= '0;
      prev_r  <= '0;
    end else begin
      sync1_r <= async_in;
      sync2_r <= sync1_r;
      prev_r  <= norm;
    end
  end

  // prev tracks norm, so a polarity flip can itself produce a rise.
  assign norm = sync2_r ^ pol;
  assign rise = norm & ~prev_r;

endmodule

// File: rtl/hs32_irq_cond.sv
// HS32 interrupt source conditioning: polarity, edge/level mode, masking and
// pending-edge latching in front of the AIC, with an MMIO register interface.
module hs32_irq_cond
  import hs32_irq_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stb,
  output logic        ack,
  input  logic [4:0]  addr,
  input  logic [31:0] dtw,
  output logic [31:0] dtr,
  input  logic        rw,
  input  logic [23:0] irq_in,
  input  logic        int_ack,
  input  logic [4:0]  int_vec,
  output logic [23:0] interrupts
);

  logic [NIRQ-1:0] mode_r;
  logic [NIRQ-1:0] pol_r;
  logic [NIRQ-1:0] mask_r;
  logic [NIRQ-1:0] pend_r;
  logic            ack_r;
  logic [31:0]     dtr_r;

  logic [NIRQ-1:0] norm_s;
  logic [NIRQ-1:0] rise_s;
  logic [NIRQ-1:0] mode_nxt_s;
  logic [NIRQ-1:0] w1c_s;
  logic [NIRQ-1:0] swi_s;
  logic [NIRQ-1:0] ack_clr_s;
  logic [NIRQ-1:0] pend_nxt_s;
  logic [31:0]     rd_data_s;
  logic            wr_s;

  hs32_irq_sync #(.W(NIRQ)) u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (irq_in),
    .pol      (pol_r),
    .norm     (norm_s),
    .rise     (rise_s)
  );

  assign wr_s = stb & rw;

  // Decode bus writes that affect mode and pending state.
  always_comb begin
    mode_nxt_s = mode_r;
    w1c_s      = '0;
    swi_s      = '0;
    if (wr_s) begin
      case (addr)
        REG_MODE: mode_nxt_s = dtw[NIRQ-1:0];
        REG_PEND: w1c_s      = dtw[NIRQ-1:0];
        REG_SWI:  swi_s      = dtw[NIRQ-1:0];
        default:  mode_nxt_s = mode_r;
      endcase
    end else begin
      mode_nxt_s = mode_r;
    end
  end

  // Vector acknowledge clears only an edge-mode line in range.
  always_comb begin
    ack_clr_s = '0;
    if (int_ack && (int_vec < 5'd24)) begin
      ack_clr_s[int_vec] = mode_r[int_vec];
    end else begin
      ack_clr_s = '0;
    end
  end

  // Set beats clear; a line leaving edge mode drops its pending bit.
  assign pend_nxt_s = ((pend_r & ~(w1c_s | ack_clr_s)) | rise_s | swi_s) & mode_nxt_s;

  // Read data mux.
  always_comb begin
    rd_data_s = 32'h0000_0000;
    case (addr)
      REG_MODE: rd_data_s = zext_lines(mode_r);
      REG_POL:  rd_data_s = zext_lines(pol_r);
      REG_PEND: rd_data_s = zext_lines(pend_r);
      REG_MASK: rd_data_s = zext_lines(mask_r | NMI_MASK);
      REG_RAW:  rd_data_s = zext_lines(norm_s);
      default:  rd_data_s = 32'h0000_0000;
    endcase
  end

  // Configuration, pending state and bus response registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_r <= '0;
      pol_r  <= '0;
      mask_r <= '0;
      pend_r <= '0;
      ack_r  <= 1'b0;
      dtr_r  <= 32'h0000_0000;
    end else begin
      mode_r <= mode_nxt_s;
      pend_r <= pend_nxt_s;
      if (wr_s && (addr == REG_POL)) begin
        pol_r <= dtw[NIRQ-1:0];
      end
      if (wr_s && (addr == REG_MASK)) begin
        mask_r <= dtw[NIRQ-1:0] & ~NMI_MASK;
      end
      ack_r <= stb;
      dtr_r <= (stb && !rw) ? rd_data_s : 32'h0000_0000;
    end
  end

  assign ack        = ack_r;
  assign dtr        = dtr_r;
  assign interrupts = ((mode_r & pend_r) | (~mode_r & norm_s)) & (mask_r | NMI_MASK);

endmodule

// File: tb/tb_hs32_irq_cond.sv
// Directed self-checking bench for hs32_irq_cond with hand-computed expectations.
module tb_hs32_irq_cond;

  logic        clk;
  logic        reset_n;
  logic        stb;
  logic        ack;
  logic [4:0]  addr;
  logic [31:0] dtw;
  logic [31:0] dtr;
  logic        rw;
  logic [23:0] irq_in;
  logic        int_ack;
  logic [4:0]  int_vec;
  logic [23:0] interrupts;

  int checks_cnt;
  int fail_cnt;
  logic [31:0] rd;

  hs32_irq_cond dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .stb        (stb),
    .ack        (ack),
    .addr       (addr),
    .dtw        (dtw),
    .dtr        (dtr),
    .rw         (rw),
    .irq_in     (irq_in),
    .int_ack    (int_ack),
    .int_vec    (int_vec),
    .interrupts (interrupts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    stb = 1'b1; rw = 1'b1; addr = a; dtw = d;
    @(negedge clk);
    stb = 1'b0; rw = 1'b0; dtw = 32'h0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    stb = 1'b1; rw = 1'b0; addr = a;
    @(negedge clk);
    d = dtr;
    check("read_ack", {31'h0, ack}, 32'h1);
    stb = 1'b0;
  endtask

  initial begin
    checks_cnt = 0;
    fail_cnt   = 0;
    reset_n = 1'b0; stb = 1'b0; rw = 1'b0; addr = 5'd0; dtw = 32'h0;
    irq_in = 24'hFFFFFF; int_ack = 1'b0; int_vec = 5'd0;

    // Reset state
    ticks(3);
    check("rst_interrupts", {8'h0, interrupts}, 32'h0);
    check("rst_ack", {31'h0, ack}, 32'h0);
    check("rst_dtr", dtr, 32'h0);
    irq_in = 24'h000000;
    reset_n = 1'b1;
    ticks(3);
    bus_read(5'd3, rd);
    check("rst_mask_read", rd, 32'h000003);
    bus_read(5'd0, rd);
    check("rst_mode_read", rd, 32'h0);

    // Level mode
    bus_write(5'd3, 32'h000010);
    irq_in[4] = 1'b1;
    ticks(1);
    check("lvl_1edge", {8'h0, interrupts}, 32'h0);
    ticks(1);
    check("lvl_2edge", {8'h0, interrupts}, 32'h000010);
    irq_in[4] = 1'b0;
    ticks(1);
    check("lvl_fall_1edge", {8'h0, interrupts}, 32'h000010);
    ticks(1);
    check("lvl_fall_2edge", {8'h0, interrupts}, 32'h0);
    irq_in[5] = 1'b1;
    ticks(3);
    check("lvl_masked", {8'h0, interrupts}, 32'h0);
    irq_in[5] = 1'b0;
    ticks(3);

    // Edge mode with vector acknowledge
    bus_write(5'd0, 32'h000100);
    bus_write(5'd3, 32'h000100);
    irq_in[8] = 1'b1;
    ticks(2);
    check("edge_2edge", {8'h0, interrupts}, 32'h0);
    ticks(1);
    check("edge_3edge", {8'h0, interrupts}, 32'h000100);
    irq_in[8] = 1'b0;
    ticks(3);
    bus_read(5'd2, rd);
    check("edge_pend_held", rd, 32'h000100);
    @(negedge clk);
    int_ack = 1'b1; int_vec = 5'd8;
    @(negedge clk);
    int_ack = 1'b0;
    check("edge_ack_clr", {8'h0, interrupts}, 32'h0);
    bus_read(5'd2, rd);
    check("edge_pend_clr", rd, 32'h0);

    // Set beats clear: new rise on line 8 at the same edge as int_ack vec 8
    bus_write(5'd5, 32'h000100);
    check("swi_set8", {8'h0, interrupts}, 32'h000100);
    irq_in[8] = 1'b1;
    ticks(2);
    int_ack = 1'b1; int_vec = 5'd8;
    @(negedge clk);
    int_ack = 1'b0;
    check("collision_keep", {8'h0, interrupts}, 32'h000100);
    @(negedge clk);
    int_ack = 1'b1; int_vec = 5'd8;
    @(negedge clk);
    int_ack = 1'b0;
    check("collision_then_clr", {8'h0, interrupts}, 32'h0);
    irq_in[8] = 1'b0;
    ticks(3);

    // Polarity and NMI
    irq_in[0] = 1'b1;
    bus_write(5'd1, 32'h000001);
    bus_write(5'd3, 32'h000000);
    ticks(3);
    check("pol_inactive", {8'h0, interrupts}, 32'h0);
    irq_in[0] = 1'b0;
    ticks(2);
    check("pol_nmi_active", {8'h0, interrupts}, 32'h000001);
    bus_write(5'd0, 32'h000401);
    irq_in[0] = 1'b1;
    ticks(3);
    irq_in[0] = 1'b0;
    ticks(3);
    check("nmi_edge_pend", {8'h0, interrupts}, 32'h000001);
    bus_write(5'd2, 32'h000001);
    check("w1c_clr", {8'h0, interrupts}, 32'h0);
    bus_write(5'd5, 32'h000C00);
    bus_read(5'd2, rd);
    check("swi_edge_only", rd, 32'h000400);
    check("swi_masked", {8'h0, interrupts}, 32'h0);
    bus_read(5'd5, rd);
    check("swi_reads0", rd, 32'h0);
    @(negedge clk);
    int_ack = 1'b1; int_vec = 5'd26;
    @(negedge clk);
    int_ack = 1'b0;
    bus_read(5'd2, rd);
    check("vec_out_of_range", rd, 32'h000400);
    bus_write(5'd3, 32'h000400);
    check("unmask_shows", {8'h0, interrupts}, 32'h000400);
    bus_write(5'd0, 32'h000001);
    bus_read(5'd2, rd);
    check("mode_to_level_clr", rd, 32'h0);

    // Bus corner cases
    bus_read(5'd7, rd);
    check("read_addr7", rd, 32'h0);
    bus_write(5'd4, 32'hFFFFFFFF);
    bus_read(5'd4, rd);
    check("raw_ro", rd, 32'h000001);
    bus_read(5'd1, rd);
    check("pol_read", rd, 32'h000001);
    @(negedge clk);
    stb = 1'b1; rw = 1'b0; addr = 5'd3;
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_mid_ack", {31'h0, ack}, 32'h0);
    check("rst_mid_dtr", dtr, 32'h0);
    stb = 1'b0;
    reset_n = 1'b1;
    bus_read(5'd0, rd);
    check("rst_mid_mode", rd, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
